t_ff_using_jk: RTL and testbench

T_FF_USING_JK -- requirements
Module: t_ff_using_jk

---
 rtl/t_ff_using_jk.sv | 63 ++++++
 tb/tb_t_ff_using_jk.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/t_ff_using_jk.sv
// t_ff_using_jk: WIDTH independent toggle flip-flops, each bit built from a JK
// stage with J = K = t[i]. An asynchronous active-low reset loads RESET_VAL.

module t_ff_using_jk_stage #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   // NOTE: state is written only with non-blocking assignments so every stage
   // samples its inputs from before the edge, whatever the evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_VAL;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

   // Derived combinationally from the single state bit, so it can never skew.
   assign qbar = ~q;

endmodule

module t_ff_using_jk #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar
);

   if (WIDTH < 1 || WIDTH > 32) begin : gen_width_check
      $error("t_ff_using_jk: WIDTH must be in 1..32");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
      t_ff_using_jk_stage #(
         .RESET_VAL (RESET_VAL[i])
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .j    (t[i]),
         .k    (t[i]),
         .q    (q[i]),
         .qbar (qbar[i])
      );
   end

endmodule

// File: tb/tb_t_ff_using_jk.sv
// Bench for t_ff_using_jk: directed reset/toggle scenarios plus randomized toggle
// and reset traffic, compared every cycle against an XOR-accumulator model.

module tb_t_ff_using_jk;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       chk_en = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic [0:0] t1 = '0, q1, qbar1;
   logic [3:0] t4 = '0, q4, qbar4;
   logic [0:0] tr = '0, qr, qbarr;
   logic [7:0] t8 = '0, q8, qbar8;

   // Model: while in reset the state is the reset value; otherwise each edge
   // adds t into the state modulo 2 per bit.
   logic [0:0] m1;
   logic [3:0] m4;
   logic [0:0] mr;
   logic [7:0] m8;

   always #5 clk = ~clk;

   t_ff_using_jk #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .t(t1), .q(q1), .qbar(qbar1));
   t_ff_using_jk #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .t(t4), .q(q4), .qbar(qbar4));
   t_ff_using_jk #(.WIDTH(1), .RESET_VAL(1'b1)) ur (.clk(clk), .rst(rst), .t(tr), .q(qr), .qbar(qbarr));
   t_ff_using_jk #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (.clk(clk), .rst(rst), .t(t8), .q(q8), .qbar(qbar8));

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m1 <= 1'b0;
         m4 <= 4'h0;
         mr <= 1'b1;
         m8 <= 8'hA5;
      end else begin
         m1 <= m1 ^ t1;
         m4 <= m4 ^ t4;
         mr <= mr ^ tr;
         m8 <= m8 ^ t8;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      logic [0:0] n1, nr;
      logic [3:0] n4;
      logic [7:0] n8;
      n1 = ~q1;
      n4 = ~q4;
      nr = ~qr;
      n8 = ~q8;
      check({tag, " q1"}, q1, m1);
      check({tag, " q4"}, q4, m4);
      check({tag, " qr"}, qr, mr);
      check({tag, " q8"}, q8, m8);
      check({tag, " qbar1"}, qbar1, n1);
      check({tag, " qbar4"}, qbar4, n4);
      check({tag, " qbarr"}, qbarr, nr);
      check({tag, " qbar8"}, qbar8, n8);
   endtask

   always @(negedge clk) begin
      if (chk_en) compare_all("cycle");
   end

   always @(rst) begin
      #1;
      if (chk_en) compare_all("rst_edge");
   end

   initial begin
      // Reset asserted with no clock edge having occurred yet.
      #2 rst = 1'b0;
      #1;
      check("init_rst q1", q1, 1'b0);
      check("init_rst qr", qr, 1'b1);
      check("init_rst q8", q8, 8'hA5);
      chk_en = 1'b1;

      // S1: reset held while clocking with t=1.
      t1 = 1'b1; t4 = 4'hF; tr = 1'b1; t8 = 8'hFF;
      repeat (3) begin
         @(posedge clk); #1;
         check("s1 q1", q1, 1'b0);
         check("s1 qbar1", qbar1, 1'b1);
         check("s6 reset qr", qr, 1'b1);
      end

      // Release mid-cycle, then S2: t=0 holds.
      t1 = 1'b0; t4 = 4'h0; tr = 1'b0; t8 = 8'h00;
      #2 rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("s2 q1", q1, 1'b0);
         check("s2 qbar1", qbar1, 1'b1);
      end

      // S3/S5/S6 together on different instances.
      for (int i = 0; i < 4; i++) begin
         t1 = 1'b1;
         t4 = (i < 2) ? 4'b0101 : 4'b0000;
         tr = (i == 0) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         check("s3 q1", q1, (i % 2 == 0) ? 1'b1 : 1'b0);
         check("s3 qbar1", qbar1, (i % 2 == 0) ? 1'b0 : 1'b1);
         check("s5 q4", q4, (i == 0) ? 4'b0101 : 4'b0000);
         check("s6 qr", qr, 1'b0);
      end

      // S4: reach q=1, then reset between edges.
      t4 = 4'b0000;
      @(posedge clk); #1;
      check("s4 pre q1", q1, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("s4 q1", q1, 1'b0);
      check("s4 qbar1", qbar1, 1'b1);
      // Held reset overrides the pending toggle on the next edge.
      @(posedge clk); #1;
      check("s4 hold q1", q1, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("s4 release q1", q1, 1'b0);
      // First edge after release toggles.
      @(posedge clk); #1;
      check("s4 first edge q1", q1, 1'b1);

      // Randomized toggles with occasional asynchronous reset pulses.
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #2;
         t1 = 1'($urandom);
         t4 = 4'($urandom);
         tr = 1'($urandom);
         t8 = 8'($urandom);
         if ($urandom_range(15) == 0) begin
            #1 rst = 1'b0;
            if ($urandom_range(1) == 1) begin
               @(posedge clk);
               #3 rst = 1'b1;
            end else begin
               #3 rst = 1'b1;
            end
         end
      end

      @(posedge clk); #2;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
